// File: rtl/riscv_trace_buffer_pkg.sv
// Shared definitions for the commit-trace recorder: state codes, trigger
// modes and the positions of the branch/jump bits inside the flag field.
package riscv_trace_buffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_POST  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DUMP  = 3'd4
  } trace_state_e;

  localparam logic [1:0] TRIG_IMM = 2'd0;
  localparam logic [1:0] TRIG_PC  = 2'd1;
  localparam logic [1:0] TRIG_BR  = 2'd2;
  localparam logic [1:0] TRIG_EXT = 2'd3;

  // Flag field layout: [15:10]=alu_ctrl, [9]=jump, [8]=beq, [7]=bneq,
  // [6]=bge, [5]=blt, [4]=reg_write, [3]=alu_src, [2]=mem_read,
  // [1]=mem_write, [0]=mem_to_reg
  localparam int FLAG_JUMP = 9;
  localparam int FLAG_BEQ  = 8;
  localparam int FLAG_BLT  = 5;

  // Width of one stored record {ts, pc, instr, flags}
  function automatic int rec_width(input int ts_w, input int xlen, input int flag_w);
    return ts_w + 2 * xlen + flag_w;
  endfunction

endpackage

// File: rtl/riscv_trace_buffer_ram.sv
// Simple dual-port record store: synchronous write, registered read.
// The array itself has no reset; contents are only meaningful after writes.
module riscv_trace_buffer_ram #(
  parameter int DEPTH = 64,
  parameter int REC_W = 96,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [REC_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [REC_W-1:0] rdata
);

  logic [REC_W-1:0] mem [DEPTH];
  logic [REC_W-1:0] rdata_p1;

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: one-cycle latency, output held while re is low
  always_ff @(posedge clk) begin
    if (re) rdata_p1 <= mem[raddr];
  end

  assign rdata = rdata_p1;

endmodule

// File: rtl/riscv_trace_buffer.sv
// Commit-trace recorder: captures {ts, pc, instr, flags} per valid cycle into
// a circular buffer, stops after a trigger plus post_count samples, then
// streams the records out oldest-first over a valid/ready interface.
module riscv_trace_buffer
  import riscv_trace_buffer_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 64,
  parameter int FLAG_W = 16,
  parameter int TS_W   = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int REC_W = rec_width(TS_W, XLEN, FLAG_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic [1:0]       trig_mode,
  input  logic [XLEN-1:0]  trig_pc,
  input  logic             trig_ext,
  input  logic [AW-1:0]    post_count,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  instr_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic             rd_start,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [REC_W-1:0] rd_data,
  output logic             rd_last,
  output logic [2:0]       state_out,
  output logic [AW:0]      count_out,
  output logic             overflow
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  trace_state_e     state, state_nxt;
  logic [TS_W-1:0]  ts;
  logic [AW-1:0]    wr_ptr, rd_ptr, post_left;
  logic [AW:0]      count, rd_left;
  logic [REC_W-1:0] ram_rdata;

  logic wr_en, trig_hit, trig_fire, post_end, xfer, rd_en, dump_end, dump_go;

  assign wr_en     = in_valid && !arm && (state == ST_ARMED || state == ST_POST);
  assign trig_fire = wr_en && (state == ST_ARMED) && trig_hit;
  assign post_end  = wr_en && (state == ST_POST) && (post_left == AW'(1));
  assign dump_go   = !arm && (state == ST_DONE) && rd_start;
  assign xfer      = rd_valid && rd_ready;
  assign rd_en     = !arm && (state == ST_DUMP) && (rd_left != '0) && (!rd_valid || rd_ready);
  assign dump_end  = (state == ST_DUMP) && xfer && rd_last;

  // Trigger condition for the selected mode (only acted on during valid ARMED cycles)
  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      TRIG_IMM: trig_hit = 1'b1;
      TRIG_PC:  trig_hit = (pc_in == trig_pc);
      TRIG_BR:  trig_hit = |flags_in[FLAG_JUMP:FLAG_BLT];
      TRIG_EXT: trig_hit = trig_ext;
      default:  trig_hit = 1'b0;
    endcase
  end

  // Next-state logic; arm overrides everything and restarts recording
  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = ST_ARMED;
    end else begin
      case (state)
        ST_ARMED: if (trig_fire) state_nxt = (post_count != '0) ? ST_POST : ST_DONE;
        ST_POST:  if (post_end)  state_nxt = ST_DONE;
        ST_DONE:  if (rd_start)  state_nxt = (count == '0) ? ST_IDLE : ST_DUMP;
        ST_DUMP:  if (dump_end)  state_nxt = ST_IDLE;
        default:  state_nxt = state;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Free-running timestamp, runs in every state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  // Capture side: write pointer, fill count, overflow flag, post-trigger countdown
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      post_left <= '0;
    end else if (arm) begin
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      post_left <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count == FULL) overflow <= 1'b1;
        else               count    <= count + (AW+1)'(1);
      end
      if (trig_fire)                      post_left <= post_count;
      else if (wr_en && state == ST_POST) post_left <= post_left - AW'(1);
    end
  end

  // Readout side: when full the oldest record sits at wr_ptr, otherwise at 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      rd_left  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else if (arm) begin
      rd_ptr   <= '0;
      rd_left  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (dump_go) begin
        rd_ptr  <= (count == FULL) ? wr_ptr : '0;
        rd_left <= count;
      end
      if (rd_en) begin
        rd_ptr   <= rd_ptr + AW'(1);
        rd_left  <= rd_left - (AW+1)'(1);
        rd_valid <= 1'b1;
        rd_last  <= (rd_left == (AW+1)'(1));
      end else if (xfer) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

  riscv_trace_buffer_ram #(
    .DEPTH (DEPTH),
    .REC_W (REC_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({ts, pc_in, instr_in, flags_in}),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign rd_data   = rd_valid ? ram_rdata : '0;
  assign state_out = state;
  assign count_out = count;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed bench for riscv_trace_buffer: capture/trigger modes, wrap-around,
// stalled readout, abort via arm and asynchronous reset.
module tb_riscv_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic [1:0]  trig_mode;
  logic [31:0] trig_pc;
  logic        trig_ext;
  logic [5:0]  post_count;
  logic        in_valid;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic [15:0] flags_in;
  logic        rd_start;
  logic        rd_valid;
  logic        rd_ready;
  logic [95:0] rd_data;
  logic        rd_last;
  logic [2:0]  state_out;
  logic [6:0]  count_out;
  logic        overflow;

  int n_pass  = 0;
  int n_total = 0;

  logic [95:0] dq[$];
  logic        lq[$];

  riscv_trace_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .trig_pc    (trig_pc),
    .trig_ext   (trig_ext),
    .post_count (post_count),
    .in_valid   (in_valid),
    .pc_in      (pc_in),
    .instr_in   (instr_in),
    .flags_in   (flags_in),
    .rd_start   (rd_start),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .state_out  (state_out),
    .count_out  (count_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ts_of(input logic [95:0] r);
    return r[95:80];
  endfunction
  function automatic logic [31:0] pc_of(input logic [95:0] r);
    return r[79:48];
  endfunction
  function automatic logic [31:0] instr_of(input logic [95:0] r);
    return r[47:16];
  endfunction
  function automatic logic [15:0] flags_of(input logic [95:0] r);
    return r[15:0];
  endfunction

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_state", state_out, 96'd1);
  endtask

  // Start a dump from DONE and collect every transferred beat
  task automatic dump(input bit toggle);
    int guard;
    bit stalled;
    logic [95:0] held;
    dq.delete();
    lq.delete();
    stalled = 1'b0;
    held = '0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("dump_enter", state_out, 96'd4);
    chk("dump_latency", rd_valid, 96'd0);
    guard = 0;
    while (state_out == 3'd4 && guard < 400) begin
      if (stalled) begin
        chk("stall_valid", rd_valid, 96'd1);
        chk("stall_data", rd_data, held);
      end
      rd_ready = toggle ? (guard % 2 == 0) : 1'b1;
      if (rd_valid && rd_ready) begin
        dq.push_back(rd_data);
        lq.push_back(rd_last);
        stalled = 1'b0;
      end else if (rd_valid) begin
        stalled = 1'b1;
        held = rd_data;
      end else begin
        stalled = 1'b0;
      end
      tick();
      guard++;
    end
    rd_ready = 1'b0;
    chk("dump_bounded", guard < 400, 96'd1);
    chk("dump_idle", state_out, 96'd0);
    chk("dump_valid_low", rd_valid, 96'd0);
  endtask

  // rd_last must be on the final beat only
  task automatic chk_last(input string tag);
    int ones;
    ones = 0;
    foreach (lq[k]) if (lq[k]) ones++;
    chk({tag, "_last_cnt"}, ones, 96'd1);
    if (lq.size() > 0) chk({tag, "_last_pos"}, lq[lq.size()-1], 96'd1);
  endtask

  // Consecutive pcs (step 4) and, optionally, consecutive timestamps
  task automatic chk_consec(input string tag, input bit with_ts);
    bit ok;
    ok = 1'b1;
    for (int k = 1; k < dq.size(); k++) begin
      if (pc_of(dq[k]) != pc_of(dq[k-1]) + 32'd4) ok = 1'b0;
      if (with_ts && ts_of(dq[k]) != ts_of(dq[k-1]) + 16'd1) ok = 1'b0;
    end
    chk(tag, ok, 96'd1);
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; trig_mode = 2'd0; trig_pc = '0; trig_ext = 1'b0;
    post_count = '0; in_valid = 1'b0; pc_in = '0; instr_in = '0; flags_in = '0;
    rd_start = 1'b0; rd_ready = 1'b0;

    // Reset values
    #1;
    chk("rst_state", state_out, 96'd0);
    chk("rst_count", count_out, 96'd0);
    chk("rst_valid", rd_valid, 96'd0);
    chk("rst_last", rd_last, 96'd0);
    chk("rst_ovf", overflow, 96'd0);
    chk("rst_data", rd_data, 96'd0);
    tick();
    tick();
    reset = 1'b1;

    // rd_start in IDLE is ignored
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("idle_rdstart", state_out, 96'd0);

    // T1: immediate trigger, post 3, five valid cycles
    trig_mode = 2'd0; post_count = 6'd3;
    do_arm();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; pc_in = 32'h100 + 32'(4*i); instr_in = 32'hA0 + 32'(i); flags_in = 16'(i);
      tick();
      if (i == 2) chk("t1_post", state_out, 96'd2);
      if (i == 3) chk("t1_done", state_out, 96'd3);
    end
    in_valid = 1'b0;
    chk("t1_count", count_out, 96'd4);
    chk("t1_ovf", overflow, 96'd0);
    dump(1'b0);
    chk("t1_len", dq.size(), 96'd4);
    if (dq.size() == 4) begin
      chk("t1_pc0", pc_of(dq[0]), 96'h100);
      chk("t1_pc3", pc_of(dq[3]), 96'h10C);
      chk("t1_instr2", instr_of(dq[2]), 96'hA2);
      chk("t1_flags1", flags_of(dq[1]), 96'd1);
    end
    chk_last("t1");

    // T2: pc-match trigger at 0x10, post 2
    trig_mode = 2'd1; trig_pc = 32'h10; post_count = 6'd2;
    do_arm();
    for (int i = 0; i <= 32; i++) begin
      in_valid = 1'b1; pc_in = 32'(4*i); instr_in = 32'h13; flags_in = 16'h0;
      tick();
    end
    in_valid = 1'b0;
    chk("t2_state", state_out, 96'd3);
    chk("t2_count", count_out, 96'd7);
    dump(1'b0);
    chk("t2_len", dq.size(), 96'd7);
    if (dq.size() == 7) begin
      chk("t2_first", pc_of(dq[0]), 96'h0);
      chk("t2_end", pc_of(dq[6]), 96'h18);
    end
    chk_consec("t2_consec", 1'b1);
    chk_last("t2");

    // T3/T4: branch trigger after wrap, stalled readout
    trig_mode = 2'd2; post_count = 6'd4;
    do_arm();
    for (int i = 0; i <= 104; i++) begin
      in_valid = 1'b1; pc_in = 32'(4*i); instr_in = 32'(i);
      flags_in = (i == 100) ? 16'h0100 : 16'hFC1F;
      tick();
    end
    in_valid = 1'b0;
    chk("t3_state", state_out, 96'd3);
    chk("t3_count", count_out, 96'd64);
    chk("t3_ovf", overflow, 96'd1);
    dump(1'b1);
    chk("t3_len", dq.size(), 96'd64);
    if (dq.size() == 64) begin
      chk("t3_first", pc_of(dq[0]), 96'hA4);
      chk("t3_end", pc_of(dq[63]), 96'h1A0);
      chk("t3_trig_flags", flags_of(dq[59]), 96'h0100);
      chk("t3_trig_pc", pc_of(dq[59]), 96'h190);
      chk("t3_old_flags", flags_of(dq[0]), 96'hFC1F);
    end
    chk_consec("t3_consec", 1'b1);
    chk_last("t3");

    // T5a: arm during DUMP
    trig_mode = 2'd0; post_count = 6'd1;
    do_arm();
    in_valid = 1'b1; pc_in = 32'h40; tick();
    pc_in = 32'h44; tick();
    in_valid = 1'b0;
    chk("t5_done", state_out, 96'd3);
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    tick();
    chk("t5_dump_valid", rd_valid, 96'd1);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t5_abort_valid", rd_valid, 96'd0);
    chk("t5_abort_state", state_out, 96'd1);
    chk("t5_abort_count", count_out, 96'd0);
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    chk("t5_rdstart_ign", state_out, 96'd1);

    // T5b: arm during POST after overflow
    trig_mode = 2'd3; post_count = 6'd5;
    do_arm();
    for (int i = 0; i < 70; i++) begin
      in_valid = 1'b1; pc_in = 32'(4*i); trig_ext = 1'b0;
      tick();
    end
    chk("t5_ovf_set", overflow, 96'd1);
    chk("t5_no_ext", state_out, 96'd1);
    trig_ext = 1'b1; tick(); trig_ext = 1'b0;
    chk("t5_ext_trig", state_out, 96'd2);
    tick();
    arm = 1'b1; tick(); arm = 1'b0; in_valid = 1'b0;
    chk("t5_post_abort", state_out, 96'd1);
    chk("t5_post_count", count_out, 96'd0);
    chk("t5_post_ovf", overflow, 96'd0);

    // T6: asynchronous reset in POST
    trig_mode = 2'd0; post_count = 6'd5;
    do_arm();
    in_valid = 1'b1; pc_in = 32'h80; tick(); tick();
    chk("t6_in_post", state_out, 96'd2);
    #3 reset = 1'b0;
    #1;
    chk("t6_state", state_out, 96'd0);
    chk("t6_count", count_out, 96'd0);
    chk("t6_valid", rd_valid, 96'd0);
    chk("t6_ovf", overflow, 96'd0);
    in_valid = 1'b0;
    tick();

    // arm with an immediate trigger in IDLE: arm only, then post 0 capture
    reset = 1'b1; arm = 1'b1; in_valid = 1'b1; pc_in = 32'h1FC; post_count = 6'd0;
    tick();
    arm = 1'b0;
    chk("idle_arm_state", state_out, 96'd1);
    chk("idle_arm_count", count_out, 96'd0);
    pc_in = 32'h200;
    tick();
    in_valid = 1'b0;
    chk("post0_done", state_out, 96'd3);
    chk("post0_count", count_out, 96'd1);
    dump(1'b0);
    chk("post0_len", dq.size(), 96'd1);
    if (dq.size() == 1) begin
      chk("post0_pc", pc_of(dq[0]), 96'h200);
      chk("post0_ts", ts_of(dq[0]), 96'd1);
    end
    chk_last("post0");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
